adt7420_sample_seq: RTL and testbench

//  Sequences ADT7420 accesses through a byte-level I2C transaction engine.

---
 rtl/adt7420_sample_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_adt7420_sample_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_sample_seq.sv
// ADT7420 sampling sequencer: one config write after enable, then a periodic
// pointer write plus 2-byte temperature read through a byte-level I2C engine.
module adt7420_sample_seq #(
    parameter int unsigned        INTERVAL  = 100_000_000,
    parameter logic [6:0]         I2C_ADDR  = 7'h4B,
    parameter logic [7:0]         CFG_VALUE = 8'h80,
    parameter int unsigned        MAX_RETRY = 3,
    parameter int unsigned        RETRY_GAP = 1000,
    parameter logic signed [15:0] ALARM_HI  = 16'sh1900,
    parameter logic signed [15:0] ALARM_LO  = 16'sh1680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    output logic        txn_req_o,
    output logic [6:0]  txn_addr_o,
    output logic        txn_rd_o,
    output logic [1:0]  txn_len_o,
    output logic [15:0] txn_wdata_o,
    input  logic        txn_ack_i,
    input  logic        txn_done_i,
    input  logic        txn_nack_i,
    input  logic [15:0] txn_rdata_i,
    output logic        temp_tvalid_o,
    output logic [15:0] temp_tdata_o,
    output logic        alarm_o,
    output logic [7:0]  err_count_o,
    output logic        busy_o
);
    localparam int TICK_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int GAP_W   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_REQ, S_CFG_WAIT, S_WAIT_TICK, S_PTR_REQ,
        S_PTR_WAIT, S_RD_REQ, S_RD_WAIT, S_BACKOFF
    } state_t;

    state_t              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [GAP_W-1:0]    gap_q;
    logic [RETRY_W-1:0]  retry_q;
    logic                pending_q;
    logic                cfg_owed_q;
    logic                txn_req_q;
    logic [6:0]          txn_addr_q;
    logic                txn_rd_q;
    logic [1:0]          txn_len_q;
    logic [15:0]         txn_wdata_q;
    logic                tvalid_q;
    logic [15:0]         tdata_q;
    logic                alarm_q;
    logic [7:0]          err_q;
    logic                busy_q;

    logic                tick_wrap_s;
    logic                retry_last_s;
    logic                req_rd_s;
    logic [1:0]          req_len_s;
    logic [15:0]         req_wdata_s;
    state_t              req_next_s;

    assign tick_wrap_s  = (tick_q == TICK_W'(INTERVAL - 1));
    assign retry_last_s = (retry_q == RETRY_W'(MAX_RETRY - 1));

    // Request fields presented by each REQ state and the WAIT state it hands over to
    always_comb begin
        req_rd_s    = 1'b0;
        req_len_s   = 2'd2;
        req_wdata_s = {8'h03, CFG_VALUE};
        req_next_s  = S_CFG_WAIT;
        case (state_q)
            S_PTR_REQ: begin
                req_rd_s    = 1'b0;
                req_len_s   = 2'd1;
                req_wdata_s = 16'h0000;
                req_next_s  = S_PTR_WAIT;
            end
            S_RD_REQ: begin
                req_rd_s    = 1'b1;
                req_len_s   = 2'd2;
                req_wdata_s = 16'h0000;
                req_next_s  = S_RD_WAIT;
            end
            default: begin
                req_rd_s    = 1'b0;
                req_len_s   = 2'd2;
                req_wdata_s = {8'h03, CFG_VALUE};
                req_next_s  = S_CFG_WAIT;
            end
        endcase
    end

    // Sequencer FSM, sample tick, retry/error bookkeeping and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            gap_q       <= '0;
            retry_q     <= '0;
            pending_q   <= 1'b0;
            cfg_owed_q  <= 1'b0;
            txn_req_q   <= 1'b0;
            txn_addr_q  <= 7'h00;
            txn_rd_q    <= 1'b0;
            txn_len_q   <= 2'd0;
            txn_wdata_q <= 16'h0000;
            tvalid_q    <= 1'b0;
            tdata_q     <= 16'h0000;
            alarm_q     <= 1'b0;
            err_q       <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            tvalid_q <= 1'b0;
            // A tick that lands while one is already queued is simply lost
            if (tick_wrap_s) begin
                tick_q    <= '0;
                pending_q <= 1'b1;
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        cfg_owed_q <= 1'b1;
                        retry_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CFG_REQ;
                    end
                end
                S_WAIT_TICK: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (pending_q) begin
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= cfg_owed_q ? S_CFG_REQ : S_PTR_REQ;
                    end
                end
                S_CFG_REQ, S_PTR_REQ, S_RD_REQ: begin
                    if (txn_req_q) begin
                        if (txn_ack_i) begin
                            txn_req_q <= 1'b0;
                            state_q   <= req_next_s;
                        end
                    end else if (!enable_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        txn_req_q   <= 1'b1;
                        txn_addr_q  <= I2C_ADDR;
                        txn_rd_q    <= req_rd_s;
                        txn_len_q   <= req_len_s;
                        txn_wdata_q <= req_wdata_s;
                    end
                end
                S_CFG_WAIT, S_PTR_WAIT, S_RD_WAIT: begin
                    if (txn_done_i) begin
                        if (txn_nack_i) begin
                            if (retry_last_s) begin
                                retry_q <= '0;
                                if (err_q != 8'hFF) begin
                                    err_q <= err_q + 8'd1;
                                end
                                busy_q  <= 1'b0;
                                state_q <= S_WAIT_TICK;
                            end else begin
                                retry_q <= retry_q + RETRY_W'(1);
                                gap_q   <= '0;
                                state_q <= S_BACKOFF;
                            end
                        end else if (state_q == S_CFG_WAIT) begin
                            retry_q    <= '0;
                            cfg_owed_q <= 1'b0;
                            tick_q     <= '0;
                            pending_q  <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_WAIT_TICK;
                        end else if (state_q == S_PTR_WAIT) begin
                            state_q <= S_RD_REQ;
                        end else begin
                            tdata_q  <= txn_rdata_i;
                            tvalid_q <= 1'b1;
                            retry_q  <= '0;
                            if ($signed(txn_rdata_i) >= ALARM_HI) begin
                                alarm_q <= 1'b1;
                            end else if ($signed(txn_rdata_i) < ALARM_LO) begin
                                alarm_q <= 1'b0;
                            end
                            busy_q  <= 1'b0;
                            state_q <= S_WAIT_TICK;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (gap_q == GAP_W'(RETRY_GAP - 1)) begin
                        state_q <= cfg_owed_q ? S_CFG_REQ : S_PTR_REQ;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txn_req_o     = txn_req_q;
    assign txn_addr_o    = txn_addr_q;
    assign txn_rd_o      = txn_rd_q;
    assign txn_len_o     = txn_len_q;
    assign txn_wdata_o   = txn_wdata_q;
    assign temp_tvalid_o = tvalid_q;
    assign temp_tdata_o  = tdata_q;
    assign alarm_o       = alarm_q;
    assign err_count_o   = err_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_adt7420_sample_seq.sv
// Bench for adt7420_sample_seq: behavioural I2C engine, sample/alarm reference
// model and a directed sequence of scenarios with randomized temperature data.
module tb_adt7420_sample_seq;
    localparam int INTERVAL = 200;
    localparam int GAP      = 40;
    localparam int LAT      = 20;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        txn_req_o;
    logic [6:0]  txn_addr_o;
    logic        txn_rd_o;
    logic [1:0]  txn_len_o;
    logic [15:0] txn_wdata_o;
    logic        txn_ack;
    logic        txn_done;
    logic        txn_nack;
    logic [15:0] txn_rdata;
    logic        temp_tvalid_o;
    logic [15:0] temp_tdata_o;
    logic        alarm_o;
    logic [7:0]  err_count_o;
    logic        busy_o;

    adt7420_sample_seq #(
        .INTERVAL(INTERVAL), .I2C_ADDR(7'h4B), .CFG_VALUE(8'h80), .MAX_RETRY(3),
        .RETRY_GAP(GAP), .ALARM_HI(16'sh1900), .ALARM_LO(16'sh1680)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable),
        .txn_req_o(txn_req_o), .txn_addr_o(txn_addr_o), .txn_rd_o(txn_rd_o),
        .txn_len_o(txn_len_o), .txn_wdata_o(txn_wdata_o), .txn_ack_i(txn_ack),
        .txn_done_i(txn_done), .txn_nack_i(txn_nack), .txn_rdata_i(txn_rdata),
        .temp_tvalid_o(temp_tvalid_o), .temp_tdata_o(temp_tdata_o), .alarm_o(alarm_o),
        .err_count_o(err_count_o), .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [1:0]  len;
        logic [15:0] wdata;
        logic [6:0]  addr;
        int          cyc;
    } txn_t;

    txn_t        log_q[$];
    bit          nack_q[$];
    logic [15:0] rdata_plan[$];
    logic [15:0] sent_q[$];
    logic [15:0] got_q[$];
    logic        alarm_got[$];
    bit          nack_all = 1'b0;
    bit          spurious = 1'b0;
    bit          req_seen = 1'b0;
    bit          model_alarm = 1'b0;
    int          n_valid = 0;
    int          done_cyc = 0;
    int          nack_done_cyc = 0;

    // Behavioural I2C engine: acks at once, finishes LAT cycles later
    initial begin
        bit          busy_e;
        bit          acked_prev;
        bit          cur_rd;
        bit          cur_nack;
        logic [15:0] cur_rdata;
        int          cnt;
        busy_e = 1'b0; acked_prev = 1'b0; cur_rd = 1'b0; cur_nack = 1'b0;
        cur_rdata = 16'h0000; cnt = 0;
        txn_ack = 1'b0; txn_done = 1'b0; txn_nack = 1'b0; txn_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (acked_prev) check("req_drop_after_ack", 32'(txn_req_o), 32'd0);
            acked_prev = 1'b0;
            txn_ack = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
            if (rst) begin
                busy_e = 1'b0;
            end else if (busy_e) begin
                check("single_outstanding", 32'(txn_req_o), 32'd0);
                cnt--;
                if (cnt == 0) begin
                    busy_e = 1'b0;
                    txn_done = 1'b1; txn_nack = cur_nack; txn_rdata = cur_rdata;
                    done_cyc = cyc;
                    if (cur_nack) nack_done_cyc = cyc;
                    if (cur_rd && !cur_nack) sent_q.push_back(cur_rdata);
                end
            end else if (txn_req_o) begin
                txn_ack = 1'b1; acked_prev = 1'b1; busy_e = 1'b1; cnt = LAT;
                log_q.push_back('{txn_rd_o, txn_len_o, txn_wdata_o, txn_addr_o, cyc});
                cur_rd   = txn_rd_o;
                cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : nack_all;
                if (txn_rd_o && rdata_plan.size() > 0) cur_rdata = rdata_plan.pop_front();
                else cur_rdata = 16'($urandom);
            end else if (spurious) begin
                spurious = 1'b0;
                txn_done = 1'b1; txn_nack = 1'b1; txn_rdata = 16'h7FFF;
            end
        end
    end

    // Sample monitor with hysteresis reference (thresholds in 1/128 degC)
    initial begin
        logic [15:0] exp_s;
        int          deg128;
        forever begin
            @(negedge clk);
            if (txn_req_o) req_seen = 1'b1;
            if (rst) begin
                model_alarm = 1'b0;
                sent_q.delete();
            end else if (temp_tvalid_o) begin
                n_valid++;
                check("tvalid_latency", 32'(cyc - done_cyc), 32'd1);
                check("sample_queue", 32'(sent_q.size()), 32'd1);
                exp_s = (sent_q.size() > 0) ? sent_q.pop_front() : 16'hxxxx;
                check("tdata", 32'(temp_tdata_o), 32'(exp_s));
                deg128 = int'($signed(exp_s));
                if (deg128 >= 50 * 128) model_alarm = 1'b1;
                else if (deg128 < 45 * 128) model_alarm = 1'b0;
                check("alarm_model", 32'(alarm_o), 32'(model_alarm));
                got_q.push_back(temp_tdata_o);
                alarm_got.push_back(alarm_o);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int start;
        int k;
        start = n_valid; k = 0;
        while (n_valid == start && k < budget) begin @(negedge clk); k++; end
        check({tag, "_seen"}, 32'(n_valid != start), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
        check({tag, "_seen"}, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_err(input string tag, input logic [7:0] v, input int budget);
        int k;
        k = 0;
        while (err_count_o !== v && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(err_count_o), 32'(v));
    endtask

    task automatic check_txn(input string tag, input int idx, input logic rd,
                             input logic [1:0] len, input logic [15:0] wdata, input bit chk_wd);
        txn_t t;
        t = log_q[idx];
        check({tag, "_rd"}, 32'(t.rd), 32'(rd));
        check({tag, "_len"}, 32'(t.len), 32'(len));
        check({tag, "_addr"}, 32'(t.addr), 32'h4B);
        if (chk_wd) check({tag, "_wdata"}, 32'(t.wdata), 32'(wdata));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(txn_req_o), 32'd0);
        check({tag, "_addr"}, 32'(txn_addr_o), 32'd0);
        check({tag, "_rd"}, 32'(txn_rd_o), 32'd0);
        check({tag, "_len"}, 32'(txn_len_o), 32'd0);
        check({tag, "_wdata"}, 32'(txn_wdata_o), 32'd0);
        check({tag, "_tvalid"}, 32'(temp_tvalid_o), 32'd0);
        check({tag, "_tdata"}, 32'(temp_tdata_o), 32'd0);
        check({tag, "_alarm"}, 32'(alarm_o), 32'd0);
        check({tag, "_err"}, 32'(err_count_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int          nl;
        int          nv;
        int          ag;
        int          cfg_writes;
        int          gap_seen;
        bit          any_busy;
        logic [15:0] alarm_in[4];
        logic        alarm_exp[4];
        alarm_in  = '{16'h1900, 16'h1700, 16'h167F, 16'h8000};
        alarm_exp = '{1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; enable = 1'b0;
        wait_cycles(4);
        check_all_zero("reset");
        rst = 1'b0;
        wait_cycles(3);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_no_txn", 32'(log_q.size()), 32'd0);

        // First sample: config write, pointer write, read of 0x0C80
        rdata_plan.push_back(16'h0C80);
        enable = 1'b1;
        wait_valid("first_sample", 400);
        check_txn("cfg", 0, 1'b0, 2'd2, 16'h0380, 1'b1);
        check_txn("ptr", 1, 1'b0, 2'd1, 16'h0000, 1'b1);
        check_txn("rd", 2, 1'b1, 2'd2, 16'h0000, 1'b0);
        check("first_tdata", 32'(temp_tdata_o), 32'h0C80);
        check("first_alarm", 32'(alarm_o), 32'd0);
        check("first_err", 32'(err_count_o), 32'd0);

        // Steady run: any 5-interval window holds exactly 5 samples
        wait_cycles(20);
        nv = n_valid; nl = log_q.size();
        wait_cycles(5 * INTERVAL);
        check("steady_samples", 32'(n_valid - nv), 32'd5);
        check("steady_txns", 32'(log_q.size() - nl), 32'd10);
        cfg_writes = 0;
        foreach (log_q[i]) if (!log_q[i].rd && log_q[i].len == 2'd2) cfg_writes++;
        check("steady_cfg_writes", 32'(cfg_writes), 32'd1);

        // One NACK on the pointer write: single retry after the gap
        wait_valid("pre_retry", 400);
        nl = log_q.size(); nv = n_valid;
        nack_q.push_back(1'b1);
        wait_valid("retry_sample", 600);
        check_txn("retry_first", nl, 1'b0, 2'd1, 16'h0000, 1'b1);
        check_txn("retry_again", nl + 1, 1'b0, 2'd1, 16'h0000, 1'b1);
        check_txn("retry_read", nl + 2, 1'b1, 2'd2, 16'h0000, 1'b0);
        gap_seen = log_q[nl + 1].cyc - nack_done_cyc;
        check("retry_gap_in_range", 32'(gap_seen >= GAP && gap_seen <= GAP + 4), 32'd1);
        check("retry_one_sample", 32'(n_valid - nv), 32'd1);
        check("retry_err", 32'(err_count_o), 32'd0);

        // Every transaction NACKed: three attempts, one error, no sample
        wait_valid("pre_fail", 400);
        nl = log_q.size(); nv = n_valid;
        nack_all = 1'b1;
        wait_err("fail_err", 8'd1, 800);
        nack_all = 1'b0;
        check("fail_attempts", 32'(log_q.size() - nl), 32'd3);
        for (int i = 0; i < 3; i++) check_txn("fail_ptr", nl + i, 1'b0, 2'd1, 16'h0000, 1'b1);
        check("fail_no_sample", 32'(n_valid - nv), 32'd0);

        // Stray done while idle between samples is ignored
        wait_valid("pre_spurious", 400);
        wait_cycles(10);
        nv = n_valid; nl = log_q.size(); any_busy = 1'b0;
        spurious = 1'b1;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (busy_o) any_busy = 1'b1; end
        check("spurious_busy", 32'(any_busy), 32'd0);
        check("spurious_err", 32'(err_count_o), 32'd1);
        check("spurious_no_sample", 32'(n_valid - nv), 32'd0);
        check("spurious_no_txn", 32'(log_q.size() - nl), 32'd0);

        // Drive the error counter to saturation and one step beyond
        nv = n_valid;
        nack_all = 1'b1;
        wait_err("sat_reach", 8'd255, 60000);
        nl = log_q.size();
        wait_log("sat_extra", nl + 3, 1200);
        wait_cycles(LAT + 10);
        check("sat_hold", 32'(err_count_o), 32'd255);
        check("sat_no_sample", 32'(n_valid - nv), 32'd0);
        nack_all = 1'b0;

        // Alarm hysteresis across set/hold/clear and a negative sample
        ag = alarm_got.size();
        foreach (alarm_in[i]) rdata_plan.push_back(alarm_in[i]);
        for (int i = 0; i < 4; i++) wait_valid("alarm_sample", 400);
        for (int i = 0; i < 4; i++) begin
            check("alarm_tdata", 32'(got_q[ag + i]), 32'(alarm_in[i]));
            check("alarm_flag", 32'(alarm_got[ag + i]), 32'(alarm_exp[i]));
        end

        // Drop enable while the read is in flight: sample still lands, then idle
        nl = log_q.size();
        wait_log("drop_read_ack", nl + 2, 400);
        check("drop_is_read", 32'(log_q[nl + 1].rd), 32'd1);
        enable = 1'b0;
        wait_valid("drop_sample", 100);
        wait_cycles(5);
        check("drop_busy", 32'(busy_o), 32'd0);
        req_seen = 1'b0;
        wait_cycles(3 * INTERVAL);
        check("drop_no_req", 32'(req_seen), 32'd0);
        check("drop_txn_count", 32'(log_q.size() - nl), 32'd2);

        // Re-enable redoes config; reset in the middle of it clears everything
        nl = log_q.size();
        enable = 1'b1;
        wait_log("reenable_cfg", nl + 1, 50);
        check_txn("reenable_cfg", nl, 1'b0, 2'd2, 16'h0380, 1'b1);
        wait_cycles(5);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        nl = log_q.size();
        wait_valid("post_rst_sample", 400);
        check_txn("post_rst_cfg", nl, 1'b0, 2'd2, 16'h0380, 1'b1);
        check("post_rst_err", 32'(err_count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
